div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Multi-cycle radix-2 restoring divider; responder side of the EX-stage start/ready divide handshake.
//  EX holds start_i high while stalled; block answers after a fixed latency with {remainder, quotient}.
//  Result layout: [31:0] quotient (goes to LO), [63:32] remainder (goes to HI).
//  Signed (DIV) and unsigned (DIVU) supported; MIPS truncating semantics.
// PARAMETERS
//  WIDTH  32  operand width; result_o is 2*WIDTH. Iteration count equals WIDTH.
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst           in   1        synchronous, active-high reset
//  signed_div_i  in   1        1 = signed divide, 0 = unsigned; sampled with start_i in IDLE
//  opdata1_i     in   WIDTH    dividend; sampled with start_i in IDLE
//  opdata2_i     in   WIDTH    divisor; sampled with start_i in IDLE
//  start_i       in   1        request; level, held high by initiator until ready_o seen
//  annul_i       in   1        cancel in-flight divide
//  result_o      out  2*WIDTH  {remainder, quotient}; valid only while ready_o=1
//  ready_o       out  1        result valid (registered)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, ready_o=0, result_o=0, internal operand/sign regs=0. Reset overrides any state.
//  States: IDLE, BYZERO, ON, END (2-bit encoding).
//  IDLE: if start_i & ~annul_i: latch operands and signed flag.
//    divisor==0 -> BYZERO; else -> ON with cnt=0.
//    Signed: store |opdata1|, |opdata2| (0x80000000 magnitude kept as unsigned 2^31);
//    q_neg = sign1^sign2, r_neg = sign1. Unsigned: q_neg=r_neg=0.
//  ON, each cycle: rem_t = {rem[W-1:0], dvd[W-1]} (W+1 bits); diff = rem_t - {1'b0,dvs};
//    diff non-negative -> rem=diff, dvd={dvd[W-2:0],1}; else rem=rem_t, dvd={dvd[W-2:0],0}.
//    cnt increments; after iteration with cnt==W-1 -> END.
//    annul_i=1 or start_i=0 -> IDLE immediately, no iteration done, ready_o stays 0.
//  BYZERO: one cycle -> END with quotient=0, remainder=0.
//  END: ready_o=1, result_o = {r_neg ? -rem : rem, q_neg ? -quo : quo}, held stable.
//    Stay in END while start_i=1. On start_i=0 -> IDLE; next cycle ready_o=0, result_o=0.
//    annul_i in END -> IDLE, same as start_i=0.
//  Latency (start_i first high in cycle N, state IDLE):
//    normal: ready_o=1 in cycle N+W+1 (N+33); div-by-zero: cycle N+2.
//  Operands are captured once; input changes after capture are ignored until the next IDLE.
//  ready_o never high except in END; never high for one cycle without a prior start.
//  Back-to-back: start_i re-asserted in the cycle after END->IDLE begins a new divide; no bubble beyond that IDLE cycle.
//  Quotient of 0x80000000 / 0xFFFFFFFF (signed) = 0x80000000 (wrap); remainder 0.
// TESTING
//  1 unsigned 100/7, hold start -> ready_o at N+33, result_o = {32'd2, 32'd14}; drop start -> ready_o=0 next cycle.
//  2 signed -7/2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; signed 7/-2 -> {32'h1, 32'hFFFFFFFD}.
//  3 divisor=0 (signed and unsigned) -> ready_o at N+2, result_o = 64'h0.
//  4 annul_i pulse at N+10 -> IDLE, ready_o never asserts; new start 3/3 then gives {0,1} at +33.
//  5 signed 0x80000000/0xFFFFFFFF -> {0, 32'h80000000}; unsigned 0xFFFFFFFF/1 -> {0, 32'hFFFFFFFF}.
//  6 rst asserted mid-ON -> next cycle ready_o=0, result_o=0, IDLE; start_i held high -> fresh divide from IDLE.

Source files
------------

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider with start/ready handshake
//
// Purpose: signed/unsigned truncating divide over WIDTH iterations. The initiator
// holds start_i high until ready_o is seen. The result is {remainder, quotient}.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   signed_div_i  1 = signed divide, 0 = unsigned (sampled with start_i in IDLE)
//   opdata1_i     dividend (sampled with start_i in IDLE)
//   opdata2_i     divisor  (sampled with start_i in IDLE)
//   start_i       level request, held until ready_o
//   annul_i       cancel an in-flight divide
//   result_o      {remainder, quotient}, valid while ready_o=1
//   ready_o       registered result-valid
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     rem_t;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   iter_rem;
    logic [WIDTH-1:0]   iter_dvd;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic               sign1;
    logic               sign2;

    always_comb begin
        // One restoring step: shift the next dividend bit into the partial
        // remainder and subtract the divisor if it fits. The dividend register
        // doubles as the quotient, filling from the LSB as it shifts out.
        rem_t    = {rem_q, dvd_q[WIDTH-1]};
        diff     = rem_t - {1'b0, dvs_q};
        iter_rem = diff[WIDTH] ? rem_t[WIDTH-1:0] : diff[WIDTH-1:0];
        iter_dvd = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};

        // Magnitudes; the most negative value negates to itself, which read
        // as unsigned is exactly its magnitude.
        sign1 = signed_div_i & opdata1_i[WIDTH-1];
        sign2 = signed_div_i & opdata2_i[WIDTH-1];
        abs1  = sign1 ? -opdata1_i : opdata1_i;
        abs2  = sign2 ? -opdata2_i : opdata2_i;

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        ready_d  = ready_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    dvd_d   = abs1;
                    dvs_d   = abs2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    q_neg_d = sign1 ^ sign2;
                    r_neg_d = sign1;
                    state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_ON: begin
                if (annul_i || !start_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = iter_rem;
                    dvd_d = iter_dvd;
                    cnt_d = cnt_q + CW'(1);
                    // Final step: publish the sign-corrected result directly so
                    // ready_o rises on the same edge the FSM enters END.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {r_neg_q ? -iter_rem : iter_rem,
                                    q_neg_q ? -iter_dvd : iter_dvd};
                    end
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                ready_d  = 1'b1;
                result_d = '0;
            end
            S_END: begin
                if (!start_i || annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed self-checking bench for div_iter
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks;
    int failures;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after a posedge in an IDLE cycle (cycle N); leaves the bench
    // #1 after the posedge that returned the DUT to IDLE, so a following call
    // exercises back-to-back starts.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [63:0] exp_res, input string nm);
        int  cyc;
        bit  seen;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            step();
            cyc++;
            if (cyc == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
            if (ready_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || cyc != lat) begin
            failures++;
            $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", nm, cyc, seen, lat);
        end
        checks++;
        if (result_o !== exp_res) begin
            failures++;
            $display("FAIL %s result: got %h expected %h", nm, result_o, exp_res);
        end
        step();
        step();
        checks++;
        if (ready_o !== 1'b1 || result_o !== exp_res) begin
            failures++;
            $display("FAIL %s hold: ready=%b result=%h expected ready=1 result=%h",
                     nm, ready_o, result_o, exp_res);
        end
        start_i = 1'b0;
        step();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL %s clear: ready=%b result=%h expected ready=0 result=0",
                     nm, ready_o, result_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL reset: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
        end
        step();
    endtask

    task automatic test_unsigned();
        do_div(1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "u100_7");
        do_div(1'b0, 32'hFFFFFFFF, 32'd1, 33, {32'd0, 32'hFFFFFFFF}, "uffff_1");
    endtask

    task automatic test_signed();
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, "s-7_2");
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, 33, {32'h00000001, 32'hFFFFFFFD}, "s7_-2");
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 33, {32'h0, 32'h80000000}, "smin_-1");
    endtask

    task automatic test_byzero();
        do_div(1'b0, 32'd55, 32'd0, 2, 64'h0, "u_by0");
        do_div(1'b1, 32'hFFFFFFF9, 32'd0, 2, 64'h0, "s_by0");
    endtask

    task automatic test_annul();
        bit early;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        early        = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (ready_o !== 1'b0) early = 1;
        end
        annul_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        annul_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o !== 1'b0) early = 1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL annul: ready_o asserted, expected 0 throughout");
        end
        do_div(1'b0, 32'd3, 32'd3, 33, {32'd0, 32'd1}, "after_annul");
    endtask

    task automatic test_reset_mid();
        signed_div_i = 1'b0;
        opdata1_i    = 32'd500;
        opdata2_i    = 32'd9;
        start_i      = 1'b1;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
        end
        do_div(1'b0, 32'd9, 32'd4, 33, {32'd1, 32'd2}, "after_rst");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_byzero();
        test_annul();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
